id_gen: RTL
===========

# id_gen

Serial identifier generator: on request, emits one token per request as a byte stream of ASCII characters, consisting of a run of letters, a run of digits, and a trailing separator. It is the transmit-side counterpart to the identifier recogniser and sources stimulus for it. Its output stream feeds a character consumer through a valid/ready handshake. Every token it produces contains at least one letter followed by at least one digit.

## Interface
- SEP_CHAR, 8'd32, separator byte emitted after the last digit
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request one token; sampled only in IDLE
- let_len  in  4  number of letters, 1..15
- dig_len  in  4  number of digits, 1..15
- let_base  in  5  first letter offset, 0..25 (0 = 'a'/'A')
- dig_base  in  4  first digit value, 0..9
- upper  in  1  1 = letters 'A'..'Z', 0 = 'a'..'z'
- char  out  8  current ASCII byte
- valid  out  1  char is valid
- ready  in  1  consumer accepts char this cycle
- busy  out  1  token in progress (state != IDLE)
- done  out  1  one-cycle pulse after separator accepted
- err  out  1  one-cycle pulse on rejected start

## Operation
- The FSM has 4 states: IDLE, LET, DIG, SEP. Reset forces IDLE. All outputs are registered and reset to 0: char=0, valid=0, busy=0, done=0, err=0.
- IDLE, start=1, request legal: latch let_len, dig_len, upper, and the current letter/digit offsets. Go to LET with valid=1 and char set to the first letter.
- A request is illegal if let_len=0, dig_len=0, let_base>25 or dig_base>9. An illegal start stays in IDLE, pulses err for 1 cycle, and emits nothing.
- A transfer occurs on a posedge where valid=1 and ready=1. Only a transfer advances the counters, the character or the state.
- While valid=1 and ready=0, char and valid hold stable indefinitely.
- LET:
  - Each transfer decrements the letter count and advances the letter offset by 1, wrapping 25 to 0 ('z' to 'a').
  - Transfer of the last letter: go to DIG, char = first digit.
- DIG:
  - Each transfer decrements the digit count and advances the digit by 1, wrapping 9 to 0.
  - Transfer of the last digit: go to SEP, char = SEP_CHAR.
- SEP:
  - Transfer: go to IDLE, valid=0, char=0, done=1 for exactly the following cycle.
- Letter byte = 8'd65 + offset if upper, else 8'd97 + offset. Digit byte = 8'd48 + value. Offset arithmetic is 5-bit modulo 26; digit arithmetic is 4-bit modulo 10.
- Inputs other than ready are ignored outside IDLE. start while busy is ignored and does not raise err.
- Latched values are used for the whole token. Changing let_len, dig_len, upper, let_base or dig_base mid-token has no effect.
- reset mid-token: next cycle in IDLE with all outputs 0. The partial token is abandoned and done is not pulsed.

## Timing
- Latency: start in cycle N gives valid=1 with the first letter in cycle N+1.
- With ready held 1, a token occupies exactly let_len+dig_len+1 consecutive valid cycles, with no bubbles between letters, digits and separator.
- done=1 is in the cycle after the separator transfer. busy=0 in that same cycle.
- start is accepted in the done cycle, so the next token's first char is valid 1 cycle later. Back-to-back tokens therefore have exactly 1 idle cycle (valid=0) between them.
- err is asserted in the cycle after the illegal start.
- busy=1 exactly while valid=1.

## Test plan
- Basic token: reset, then start with let_len=2, dig_len=3, let_base=0, dig_base=0, upper=0, ready=1. Required stream: "ab012 " (97,98,48,49,50,32) on 6 consecutive cycles, then done=1 for 1 cycle.
- Wrap-around: let_len=3, let_base=24, dig_len=2, dig_base=9, upper=1. Required stream: "YZA90 " (89,90,65,57,48,32).
- Back-pressure: the basic token with ready toggled 1,0,0,1,... Each char must be held stable while ready=0, with no loss or duplication. The final stream is identical to the basic token.
- Illegal requests: start with dig_len=0 must give err=1 one cycle later, valid stays 0. Repeat for let_base=26 and dig_base=10.
- Ignored inputs: start pulsed and let_len changed mid-token. The output is unchanged, err stays 0, and the token length matches the originally latched value.
- Reset: assert reset during the DIG state. Next cycle valid=0, char=0, busy=0, and done is never pulsed. A subsequent start produces a complete, correct token.

Source files
------------

// File: rtl/id_gen.sv
// Serial identifier generator: letters, digits, then separator, one token per start.
// Latency: first char valid the cycle after start; valid/char hold while ready is low.
module id_gen #(
    parameter logic [7:0] SEP_CHAR = 8'd32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] let_len,
    input  logic [3:0] dig_len,
    input  logic [4:0] let_base,
    input  logic [3:0] dig_base,
    input  logic       upper,
    output logic [7:0] char,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, LET, DIG, SEP} state_t;

    // Per-token context, latched at start and owned by the FSM until the separator.
    typedef struct packed {
        logic [3:0] let_cnt;
        logic [3:0] dig_cnt;
        logic [4:0] let_off;
        logic [3:0] dig_val;
        logic       upper;
    } tok_t;

    state_t     state;
    tok_t       tok;
    logic       xfer;
    logic       illegal;
    logic [4:0] let_nxt;
    logic [3:0] dig_nxt;

    function automatic logic [7:0] letter_byte(input logic [4:0] off, input logic up);
        letter_byte = (up ? 8'd65 : 8'd97) + {3'b000, off};
    endfunction

    function automatic logic [7:0] digit_byte(input logic [3:0] val);
        digit_byte = 8'd48 + {4'b0000, val};
    endfunction

    always_comb begin
        xfer    = valid && ready;
        illegal = (let_len == 4'd0) || (dig_len == 4'd0) ||
                  (let_base > 5'd25) || (dig_base > 4'd9);
        let_nxt = (tok.let_off == 5'd25) ? 5'd0 : tok.let_off + 5'd1;
        dig_nxt = (tok.dig_val == 4'd9)  ? 4'd0 : tok.dig_val + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tok   <= '0;
            char  <= 8'd0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            tok.let_cnt <= let_len;
                            tok.dig_cnt <= dig_len;
                            tok.let_off <= let_base;
                            tok.dig_val <= dig_base;
                            tok.upper   <= upper;
                            char        <= letter_byte(let_base, upper);
                            valid       <= 1'b1;
                            busy        <= 1'b1;
                            state       <= LET;
                        end
                    end
                end
                LET: begin
                    if (xfer) begin
                        if (tok.let_cnt == 4'd1) begin
                            char  <= digit_byte(tok.dig_val);
                            state <= DIG;
                        end else begin
                            tok.let_cnt <= tok.let_cnt - 4'd1;
                            tok.let_off <= let_nxt;
                            char        <= letter_byte(let_nxt, tok.upper);
                        end
                    end
                end
                DIG: begin
                    if (xfer) begin
                        if (tok.dig_cnt == 4'd1) begin
                            char  <= SEP_CHAR;
                            state <= SEP;
                        end else begin
                            tok.dig_cnt <= tok.dig_cnt - 4'd1;
                            tok.dig_val <= dig_nxt;
                            char        <= digit_byte(dig_nxt);
                        end
                    end
                end
                SEP: begin
                    if (xfer) begin
                        char  <= 8'd0;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
